// File: rtl/rtlola_queue_scheduler.sv
// rtlola_queue_scheduler: sequences push/pop commands to an RTLola time-tracking
// queue. Event writes and periodic evaluation pops are arbitrated so that only
// one single-cycle command is outstanding; acks are awaited with a timeout.
// Optional build macro SCHED_DROP_COUNT_EN adds drop_cnt (events refused while full).
module rtlola_queue_scheduler #(
  parameter  int DATA_W      = 64,
  parameter  int DEPTH       = 4,
  parameter  int PERIOD      = 8,
  parameter  int ACK_TIMEOUT = 4,
  localparam int OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic signed [DATA_W-1:0] ev_data,
  output logic                     q_push,
  output logic                     q_pop,
  output logic signed [DATA_W-1:0] q_data,
  input  logic                     q_push_valid,
  input  logic                     q_pop_valid,
  input  logic signed [DATA_W-1:0] q_out,
  input  logic signed [DATA_W-1:0] q_waited,
  output logic                     res_valid,
  output logic signed [DATA_W-1:0] res_data,
  output logic signed [DATA_W-1:0] res_waited,
  output logic [OCC_W-1:0]         occupancy,
  output logic                     missed_tick,
  output logic                     ack_err
`ifdef SCHED_DROP_COUNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);
  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PUSH_ISSUE, PUSH_WAIT, POP_ISSUE, POP_WAIT} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [TMR_W-1:0]   tmr;
  logic               pop_pend;
  logic               res_vld_r;
  logic               tick, push_ack, pop_ack, waiting, expired, accept;

  assign tick     = (cnt == CNT_W'(PERIOD - 1));
  // an ack during the issue cycle itself counts
  assign push_ack = ((state == PUSH_ISSUE) || (state == PUSH_WAIT)) && q_push_valid;
  assign pop_ack  = ((state == POP_ISSUE)  || (state == POP_WAIT))  && q_pop_valid;
  assign waiting  = (state == PUSH_WAIT) || (state == POP_WAIT);
  assign expired  = waiting && (tmr == TMR_W'(ACK_TIMEOUT - 1)) && !(push_ack || pop_ack);
  assign accept   = ev_valid && ev_ready;

  // state register; en low freezes the sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    state <= IDLE;
    else if (en) state <= state_nx;
  end

  // next state: a pending pop outranks a waiting event
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (pop_pend) begin
          if (occupancy != '0) state_nx = POP_ISSUE;
        end else if (accept) begin
          state_nx = PUSH_ISSUE;
        end
      end
      PUSH_ISSUE: state_nx = push_ack ? IDLE : PUSH_WAIT;
      PUSH_WAIT:  if (push_ack || expired) state_nx = IDLE;
      POP_ISSUE:  state_nx = pop_ack ? IDLE : POP_WAIT;
      POP_WAIT:   if (pop_ack || expired) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // outputs: registered-state decode, all gated by en (ev_ready also by reset)
  always_comb begin
    ev_ready    = rst && en && (state == IDLE) && !pop_pend && (occupancy < OCC_W'(DEPTH));
    q_push      = en && (state == PUSH_ISSUE);
    q_pop       = en && (state == POP_ISSUE);
    missed_tick = en && (state == IDLE) && pop_pend && (occupancy == '0);
    ack_err     = en && expired;
    res_valid   = en && res_vld_r;
  end

  // tick counter, pending pop, ack timer, occupancy and data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      pop_pend   <= 1'b0;
      tmr        <= '0;
      occupancy  <= '0;
      q_data     <= '0;
      res_vld_r  <= 1'b0;
      res_data   <= '0;
      res_waited <= '0;
    end else if (en) begin
      cnt       <= tick ? '0 : cnt + 1'b1;
      // IDLE always consumes the pending pop; a fresh tick re-arms it
      pop_pend  <= tick || (pop_pend && (state != IDLE));
      tmr       <= (waiting && (state_nx == state)) ? tmr + 1'b1 : '0;
      res_vld_r <= pop_ack;
      if (state == IDLE && !pop_pend && accept) q_data <= ev_data;
      if (pop_ack) begin
        res_data   <= q_out;
        res_waited <= q_waited;
      end
      // saturate both ways in case the queue acks unexpectedly
      if (push_ack && occupancy != OCC_W'(DEPTH)) occupancy <= occupancy + 1'b1;
      else if (pop_ack && occupancy != '0)         occupancy <= occupancy - 1'b1;
    end
  end

`ifdef SCHED_DROP_COUNT_EN
  // count enabled cycles where an offered event is refused because the queue is full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else if (en && ev_valid && !ev_ready && occupancy == OCC_W'(DEPTH) && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rtlola_queue_scheduler.sv
// Bench for rtlola_queue_scheduler: transaction-level model plus directed scenarios.
module tb_rtlola_queue_scheduler;
  localparam int DW = 64, DEPTH = 4, PERIOD = 8, AT = 4;

  logic clk = 0, rst = 0, en = 1, ev_valid = 0, q_push_valid = 0, q_pop_valid = 0;
  logic signed [DW-1:0] ev_data = 0, q_out = 0, q_waited = 0;
  logic ev_ready, q_push, q_pop, res_valid, missed_tick, ack_err;
  logic signed [DW-1:0] q_data, res_data, res_waited;
  logic [2:0] occupancy;
`ifdef SCHED_DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  rtlola_queue_scheduler #(.DATA_W(DW), .DEPTH(DEPTH), .PERIOD(PERIOD), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .en(en), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .q_push(q_push), .q_pop(q_pop), .q_data(q_data), .q_push_valid(q_push_valid),
    .q_pop_valid(q_pop_valid), .q_out(q_out), .q_waited(q_waited), .res_valid(res_valid),
    .res_data(res_data), .res_waited(res_waited), .occupancy(occupancy),
    .missed_tick(missed_tick), .ack_err(ack_err)
`ifdef SCHED_DROP_COUNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit auto_push = 0, auto_pop = 0;

  // model: the command in flight (0 none, 1 push, 2 pop), whether it has been
  // sent, how long we have waited for its ack, and the believed queue content size
  int m_cnt, m_cmd, m_wait, m_occ, m_drop;
  bit m_pend, m_issued, m_res_v;
  logic signed [DW-1:0] m_qdata, m_res_d, m_res_w;

  // observation log built by the compare process
  int cyc = 0, missed_cnt = 0, qpop_cnt = 0, push_cyc = 0, err_cyc = 0;
  bit res_seen = 0, err_seen = 0;
  logic signed [DW-1:0] res_cap_d, res_cap_w;
  int cmd_log[$];
  logic signed [DW-1:0] push_log[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tmo(string name);
    tests++; fails++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cmd = 0; m_wait = 0; m_occ = 0; m_drop = 0;
    m_pend = 0; m_issued = 0; m_res_v = 0; m_qdata = 0; m_res_d = 0; m_res_w = 0;
  endtask

  function automatic bit e_ready();
    return rst && en && m_cmd == 0 && !m_pend && m_occ < DEPTH;
  endfunction

  function automatic bit ack_now();
    return (m_cmd == 1) ? q_push_valid : (m_cmd == 2) ? q_pop_valid : 1'b0;
  endfunction

  // one enabled clock of the scheduling rules
  task automatic model_edge();
    bit idle, rdy, tick, ack;
    int occ0;
    if (!rst || !en) return;
    idle = (m_cmd == 0); rdy = e_ready(); tick = (m_cnt == PERIOD - 1); occ0 = m_occ;
    ack = ack_now();
    m_cnt = (m_cnt + 1) % PERIOD;
    m_res_v = 0;
    if (idle) begin
      if (m_pend) begin
        if (m_occ > 0) begin m_cmd = 2; m_issued = 0; end
      end else if (ev_valid && rdy) begin
        m_cmd = 1; m_issued = 0; m_qdata = ev_data;
      end
    end else if (ack) begin
      if (m_cmd == 1) m_occ = (m_occ < DEPTH) ? m_occ + 1 : DEPTH;
      else begin
        m_res_v = 1; m_res_d = q_out; m_res_w = q_waited;
        if (m_occ > 0) m_occ = m_occ - 1;
      end
      m_cmd = 0;
    end else if (!m_issued) begin
      m_issued = 1; m_wait = 0;
    end else if (m_wait == AT - 1) m_cmd = 0;
    else m_wait++;
    m_pend = tick || (m_pend && !idle);
    if (ev_valid && !rdy && occ0 == DEPTH && m_drop < 16'hFFFF) m_drop++;
  endtask

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    chk("ev_ready", 64'(ev_ready), 64'(e_ready()));
    chk("q_push", 64'(q_push), 64'(en && m_cmd == 1 && !m_issued));
    chk("q_pop", 64'(q_pop), 64'(en && m_cmd == 2 && !m_issued));
    chk("missed_tick", 64'(missed_tick), 64'(en && m_cmd == 0 && m_pend && m_occ == 0));
    chk("ack_err", 64'(ack_err), 64'(en && m_cmd != 0 && m_issued && m_wait == AT - 1 && !ack_now()));
    chk("res_valid", 64'(res_valid), 64'(en && m_res_v));
    chk("occupancy", 64'(occupancy), 64'(m_occ));
    chk("q_data", q_data, m_qdata);
    chk("res_data", res_data, m_res_d);
    chk("res_waited", res_waited, m_res_w);
    chk("push_pop_excl", 64'(q_push && q_pop), 64'd0);
`ifdef SCHED_DROP_COUNT_EN
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
    if (missed_tick) missed_cnt <= missed_cnt + 1;
    if (q_pop) begin qpop_cnt <= qpop_cnt + 1; cmd_log.push_back(2); end
    if (q_push) begin push_cyc <= cyc; cmd_log.push_back(1); push_log.push_back(q_data); end
    if (ack_err) begin err_seen <= 1; err_cyc <= cyc; end
    if (res_valid) begin res_seen <= 1; res_cap_d <= res_data; res_cap_w <= res_waited; end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    q_push_valid = auto_push && en && m_cmd == 1 && !m_issued;
    q_pop_valid  = auto_pop  && en && m_cmd == 2 && !m_issued;
  endtask

  task automatic wait_free(string name);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (e_ready()) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo(name);
  endtask

  task automatic push_event(logic signed [DW-1:0] v);
    wait_free("ev_accept");
    ev_valid = 1; ev_data = v;
    step();
    ev_valid = 0;
  endtask

  task automatic wait_cmd_done(string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_cmd == 0) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo(name);
  endtask

  task automatic do_reset();
    rst = 0; model_reset();
    step(); step();
    rst = 1;
  endtask

  initial begin
    bit ok;
    model_reset();
    // reset state
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_q_push", 64'(q_push), 64'd0);
    chk("rst_ev_ready", 64'(ev_ready), 64'd0);
    chk("rst_q_data", q_data, 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    step(); step();
    rst = 1;

    // idle with empty queue: missed tick on cycles after edges 8, 16, 24
    missed_cnt = 0; qpop_cnt = 0;
    repeat (26) step();
    chk("idle_missed_cnt", 64'(missed_cnt), 64'd3);
    chk("idle_qpop_cnt", 64'(qpop_cnt), 64'd0);
    chk("idle_occ", 64'(occupancy), 64'd0);

    // fill with 1..4 (pops are not acked yet, so they time out harmlessly)
    auto_push = 1; auto_pop = 0; push_log.delete();
    for (int v = 1; v <= 4; v++) push_event(64'(v));
    wait_cmd_done("fill_done");
    step();
    chk("fill_occ", 64'(occupancy), 64'd4);
    chk("fill_ev_ready", 64'(ev_ready), 64'd0);
    chk("fill_npush", 64'(push_log.size()), 64'd4);
    if (push_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("fill_q_data", push_log[i], 64'(i + 1));

    // full queue plus tick: pop acked with q_out=1, q_waited=7
    auto_pop = 1; q_out = 1; q_waited = 7; res_seen = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_seen) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo("pop_result");
    chk("pop_res_data", res_cap_d, 64'sd1);
    chk("pop_res_waited", res_cap_w, 64'sd7);
    chk("pop_occ", 64'(occupancy), 64'd3);

    // event accepted on the same edge as a tick: push of 5 then pop
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (e_ready() && m_cnt == PERIOD - 1) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo("tick_align");
    cmd_log.delete(); push_log.delete();
    ev_valid = 1; ev_data = 5;
    step();
    ev_valid = 0;
    repeat (10) step();
    if (cmd_log.size() >= 2 && push_log.size() >= 1) begin
      chk("order_first_push", 64'(cmd_log[0]), 64'd1);
      chk("order_then_pop", 64'(cmd_log[1]), 64'd2);
      chk("order_push_data", push_log[0], 64'sd5);
    end else tmo("order_cmds");

    // push without ack: ack_err four cycles after q_push, occupancy kept
    do_reset();
    auto_push = 0; auto_pop = 0; err_seen = 0;
    push_event(64'sd9);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (err_seen) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo("ack_err");
    chk("ack_err_latency", 64'(err_cyc - push_cyc), 64'd4);
    chk("ack_err_occ", 64'(occupancy), 64'd0);
    auto_push = 1; push_log.delete();
    push_event(64'sd10);
    wait_cmd_done("push_after_err");
    chk("after_err_occ", 64'(occupancy), 64'd1);
    chk("after_err_data", (push_log.size() > 0) ? push_log[$] : 64'sd0, 64'sd10);

    // en low freezes everything and silences handshakes
    wait_free("pre_en");
    en = 0;
    repeat (3) step();
    chk("en0_ev_ready", 64'(ev_ready), 64'd0);
    chk("en0_occ", 64'(occupancy), 64'd1);
    en = 1;

    // reset while waiting for a pop ack
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_cmd == 2 && m_issued) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo("pop_wait");
    rst = 0; model_reset();
    #1;
    chk("rstmid_q_pop", 64'(q_pop), 64'd0);
    chk("rstmid_occ", 64'(occupancy), 64'd0);
    chk("rstmid_q_data", q_data, 64'd0);
    chk("rstmid_res_valid", 64'(res_valid), 64'd0);
    chk("rstmid_ack_err", 64'(ack_err), 64'd0);
    step(); step();
    rst = 1;

`ifdef SCHED_DROP_COUNT_EN
    // three refused event cycles at full occupancy
    auto_push = 1; auto_pop = 0;
    for (int v = 1; v <= 4; v++) push_event(64'(v));
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_occ == DEPTH) begin ok = 1; break; end
      step();
    end
    if (!ok) tmo("drop_fill");
    ev_valid = 1;
    repeat (3) step();
    ev_valid = 0;
    step();
    chk("drop_cnt_3", 64'(drop_cnt), 64'd3);
`endif

    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
